smooth_sched: RTL and testbench

SMOOTH_SCHED -- requirements
Module: smooth_sched

---
 rtl/smooth_sched.sv | 197 +++++++++++++++++++
 tb/tb_smooth_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/smooth_sched.sv
// smooth_sched: three-axis moving-average smoother with a sample scheduler.
//
// A sample request (divider tick or manual trig) captures in_x/in_y/in_z into
// three 16-entry history rings. The block then averages the N most recent
// entries of each axis (N = 1, 2, 4 or 16, chosen by SW at capture time) through
// one shared 20-bit adder, one addition per cycle, in the axis order X, Y, Z.
//
// Ports:
//   clk        system clock, all state updates on its rising edge
//   reset      synchronous, active-low reset
//   in_x/y/z   16-bit two's-complement axis samples
//   SW         window select: 00->N=1, 01->N=2, 10->N=4, 11->N=16
//   trig       manual sample request (one extra request per cycle held high)
//   out_x/y/z  registered smoothed values, each updated when its axis completes
//   out_valid  one-cycle pulse while a complete new result set is on the outputs
//   busy       high whenever the scheduler is not idle
//   overrun    sticky flag, set when a request arrives while busy
module smooth_sched #(
  parameter int TICK_DIV = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_x,
  input  logic [15:0] in_y,
  input  logic [15:0] in_z,
  input  logic [1:0]  SW,
  input  logic        trig,
  output logic [15:0] out_x,
  output logic [15:0] out_y,
  output logic [15:0] out_z,
  output logic        out_valid,
  output logic        busy,
  output logic        overrun
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, ACCUM, DONE} state_t;

  state_t           state_reg;
  logic [DIV_W-1:0] div_reg;
  logic [3:0]       wp_reg;
  logic [1:0]       win_sel_reg;
  logic [1:0]       axis_reg;
  logic [3:0]       k_reg;
  logic [19:0]      acc_reg;
  logic [15:0]      out_x_reg, out_y_reg, out_z_reg;
  logic             out_valid_reg, busy_reg, overrun_reg;

  logic        tick, req, wr_en, last_k;
  logic [3:0]  last_k_val, k_next, rd_addr;
  logic [2:0]  shamt;
  logic [15:0] rd_sel, res;
  logic [19:0] sum;
  logic [15:0] axis_rd [3];

  assign tick  = (div_reg == DIV_LAST);
  assign req   = tick | trig;
  assign wr_en = (state_reg == IDLE) && req;

  // Window decode: index of the last addition and the matching divide shift.
  always_comb begin
    last_k_val = 4'd0;
    shamt      = 3'd0;
    unique case (win_sel_reg)
      2'b00:   begin last_k_val = 4'd0;  shamt = 3'd0; end
      2'b01:   begin last_k_val = 4'd1;  shamt = 3'd1; end
      2'b10:   begin last_k_val = 4'd3;  shamt = 3'd2; end
      default: begin last_k_val = 4'd15; shamt = 3'd4; end
    endcase
  end

  assign last_k = (k_reg == last_k_val);

  // The rings have a one-cycle read latency, so the address for the next
  // addition is issued one cycle ahead: CAPTURE fetches k=0 of X, and each
  // ACCUM cycle fetches the entry used in the following cycle. After an
  // axis's last addition the next fetch is k=0 again (for the next axis).
  always_comb begin
    k_next = 4'd0;
    if (state_reg == ACCUM && !last_k)
      k_next = k_reg + 4'd1;
    rd_addr = wp_reg - 4'd1 - k_next;
  end

  always_comb begin
    rd_sel = 16'd0;
    unique case (axis_reg)
      2'd0:    rd_sel = axis_rd[0];
      2'd1:    rd_sel = axis_rd[1];
      default: rd_sel = axis_rd[2];
    endcase
  end

  // Shared adder; the first addition of an axis starts from zero instead of
  // the stale accumulator, which is how the per-axis clear is folded in.
  assign sum = (k_reg == 4'd0 ? 20'd0 : acc_reg) + {{4{rd_sel[15]}}, rd_sel};
  assign res = 16'($signed(sum) >>> shamt);

  // Per-axis history ring with registered read.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_axis
      logic [15:0] mem [16];
      logic [15:0] din;
      logic [15:0] rd_q;

      assign din = (gi == 0) ? in_x : (gi == 1) ? in_y : in_z;

      always_ff @(posedge clk) begin
        if (!reset) begin
          for (int i = 0; i < 16; i++)
            mem[i] <= 16'd0;
          rd_q <= 16'd0;
        end else begin
          if (wr_en)
            mem[wp_reg] <= din;
          rd_q <= mem[rd_addr];
        end
      end

      assign axis_rd[gi] = rd_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      div_reg       <= '0;
      wp_reg        <= 4'd0;
      win_sel_reg   <= 2'd0;
      axis_reg      <= 2'd0;
      k_reg         <= 4'd0;
      acc_reg       <= 20'd0;
      out_x_reg     <= 16'd0;
      out_y_reg     <= 16'd0;
      out_z_reg     <= 16'd0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      div_reg       <= tick ? '0 : div_reg + 1'b1;
      out_valid_reg <= 1'b0;
      if (req && state_reg != IDLE)
        overrun_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (req) begin
            wp_reg      <= wp_reg + 4'd1;
            win_sel_reg <= SW;
            busy_reg    <= 1'b1;
            state_reg   <= CAPTURE;
          end
        end
        CAPTURE: begin
          axis_reg  <= 2'd0;
          k_reg     <= 4'd0;
          state_reg <= ACCUM;
        end
        ACCUM: begin
          acc_reg <= sum;
          if (last_k) begin
            k_reg <= 4'd0;
            case (axis_reg)
              2'd0:    out_x_reg <= res;
              2'd1:    out_y_reg <= res;
              default: out_z_reg <= res;
            endcase
            if (axis_reg == 2'd2) begin
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else begin
              axis_reg <= axis_reg + 2'd1;
            end
          end else begin
            k_reg <= k_reg + 4'd1;
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign out_x     = out_x_reg;
  assign out_y     = out_y_reg;
  assign out_z     = out_z_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_smooth_sched.sv
// Testbench for smooth_sched (TICK_DIV = 64): directed scenarios plus random
// traffic, all cross-checked every cycle against a behavioural model that
// keeps per-axis sample histories and request timing as plain arithmetic.
module tb_smooth_sched;
  localparam int TICK = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] in_x = '0, in_y = '0, in_z = '0;
  logic [1:0]  SW = '0;
  logic        trig = 1'b0;
  logic [15:0] out_x, out_y, out_z;
  logic        out_valid, busy, overrun;

  int n_checks = 0;
  int n_fail   = 0;

  smooth_sched #(.TICK_DIV(TICK)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_z      (in_z),
    .SW        (SW),
    .trig      (trig),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_z     (out_z),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] hx[$], hy[$], hz[$];
  int          cyc = 0, free_at = 0, done_at = -1, n_pend = 1;
  bit          armed = 0, in_rst = 0, ovr_m = 0;
  logic [15:0] ex = '0, ey = '0, ez = '0;

  function automatic int win_n(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : (s == 2'd2) ? 4 : 16;
  endfunction

  // Mean of the n most recent samples, floor-divided (arithmetic shift).
  function automatic logic [15:0] avg(input logic [15:0] h[$], input int n);
    int s;
    int sh;
    s = 0;
    for (int k = 0; k < n; k++)
      s += int'($signed(h[h.size() - 1 - k]));
    sh = (n == 1) ? 0 : (n == 2) ? 1 : (n == 4) ? 2 : 4;
    s = s >>> sh;
    return s[15:0];
  endfunction

  task automatic clear_hist();
    hx.delete(); hy.delete(); hz.delete();
    for (int i = 0; i < 16; i++) begin
      hx.push_back(16'd0); hy.push_back(16'd0); hz.push_back(16'd0);
    end
  endtask

  always @(negedge clk) begin
    bit req;
    if (armed) begin
      check_eq("out_valid", out_valid, cyc == done_at);
      check_eq("busy", busy, cyc < free_at);
      check_eq("overrun", overrun, ovr_m);
      if (in_rst || cyc == done_at) begin
        check_eq("out_x", out_x, ex);
        check_eq("out_y", out_y, ey);
        check_eq("out_z", out_z, ez);
      end
      if (cyc == done_at && !in_rst)
        $display("txn done cyc=%0d N=%0d x=%04h y=%04h z=%04h", cyc, n_pend, out_x, out_y, out_z);
    end
    if (!reset) begin
      armed = 1; in_rst = 1; clear_hist();
      cyc = 0; free_at = 0; done_at = -1; ovr_m = 0;
      ex = '0; ey = '0; ez = '0;
    end else if (armed) begin
      in_rst = 0;
      req = trig || (cyc % TICK == TICK - 1);
      if (req) begin
        if (cyc >= free_at) begin
          hx.push_back(in_x); hy.push_back(in_y); hz.push_back(in_z);
          void'(hx.pop_front()); void'(hy.pop_front()); void'(hz.pop_front());
          n_pend  = win_n(SW);
          ex = avg(hx, n_pend); ey = avg(hy, n_pend); ez = avg(hz, n_pend);
          done_at = cyc + 3 * n_pend + 2;
          free_at = done_at + 1;
        end else begin
          ovr_m = 1;
        end
      end
      cyc++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    reset = 1'b0; trig = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Wait for idle, pulse trig with the given sample, then wait for out_valid.
  // lat = cycles from the request cycle to the out_valid cycle.
  task automatic do_req(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                        input logic [1:0] sw, input logic [1:0] sw_mid,
                        input int extra_at, output int lat);
    int g;
    g = 0;
    while (busy && g < 300) begin
      @(posedge clk); #1; g++;
    end
    check_eq("idle_wait", busy, 1'b0);
    in_x = x; in_y = y; in_z = z; SW = sw; trig = 1'b1;
    @(posedge clk); #1;
    trig = 1'b0; SW = sw_mid;
    in_x = 16'($urandom); in_y = 16'($urandom); in_z = 16'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
      trig = (lat == extra_at);
    end
    trig = 1'b0;
  endtask

  initial begin
    int lat, c, cnt;

    // Reset state and first tick
    do_reset();
    check_eq("rst_out_x", out_x, 16'd0);
    check_eq("rst_out_y", out_y, 16'd0);
    check_eq("rst_out_z", out_z, 16'd0);
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_overrun", overrun, 1'b0);
    SW = 2'b00; in_x = 16'h1234; in_y = 16'h8001; in_z = 16'h0042;
    c = 0;
    while (!busy && c < 200) begin @(posedge clk); #1; c++; end
    check_eq("first_tick", c - 1, 63);
    c = 0;
    while (!out_valid && c < 50) begin @(posedge clk); #1; c++; end
    check_eq("tick_out_x", out_x, 16'h1234);

    // Pass-through, N=1
    do_req(16'h0100, 16'hFF00, 16'h7FFF, 2'b00, 2'b00, 0, lat);
    check_eq("pt_latency", lat, 5);
    check_eq("pt_out_x", out_x, 16'h0100);
    check_eq("pt_out_y", out_y, 16'hFF00);
    check_eq("pt_out_z", out_z, 16'h7FFF);

    // Signed fill, N=16
    do_reset();
    do_req(16'hFFFD, 16'h0003, 16'h0000, 2'b11, 2'b11, 0, lat);
    check_eq("fill1_latency", lat, 50);
    check_eq("fill1_out_x", out_x, 16'hFFFF);
    for (int i = 1; i < 16; i++)
      do_req(16'hFFFD, 16'h0003, 16'h0000, 2'b11, 2'b11, 0, lat);
    check_eq("fill16_latency", lat, 50);
    check_eq("fill16_out_x", out_x, 16'hFFFD);

    // Window 4, SW changed during the last accumulation
    do_reset();
    for (int i = 1; i <= 4; i++)
      do_req(16'(4 * i), 16'hFFFF, 16'd0, 2'b10, (i == 4) ? 2'b00 : 2'b10, 0, lat);
    check_eq("w4_latency", lat, 14);
    check_eq("w4_out_x", out_x, 16'h000A);

    // Ring wrap, N=16
    do_reset();
    for (int i = 0; i < 16; i++)
      do_req(16'h0010, 16'h0000, 16'h0000, 2'b11, 2'b11, 0, lat);
    check_eq("wrap16_out_x", out_x, 16'h0010);
    do_req(16'h0000, 16'h0000, 16'h0000, 2'b11, 2'b11, 0, lat);
    check_eq("wrap17_out_x", out_x, 16'h000F);
    for (int i = 0; i < 15; i++)
      do_req(16'h0000, 16'h0000, 16'h0000, 2'b11, 2'b11, 0, lat);
    check_eq("wrap32_out_x", out_x, 16'h0000);

    // Overrun: second trig during ACCUM is dropped
    do_reset();
    check_eq("ovr_clear", overrun, 1'b0);
    do_req(16'h0055, 16'h0000, 16'h0000, 2'b10, 2'b10, 4, lat);
    check_eq("ovr_latency", lat, 14);
    check_eq("ovr_out_x", out_x, 16'h0015);
    check_eq("ovr_set", overrun, 1'b1);
    cnt = 0;
    repeat (20) begin @(posedge clk); #1; if (out_valid) cnt++; end
    check_eq("ovr_single_valid", cnt, 0);

    // Reset in the middle of ACCUM
    trig = 1'b1; SW = 2'b11; in_x = 16'h7000;
    @(posedge clk); #1 trig = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("mid_busy", busy, 1'b1);
    check_eq("mid_pre_out_x", out_x, 16'h0015);
    reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    check_eq("mid_out_x", out_x, 16'd0);
    check_eq("mid_overrun", overrun, 1'b0);
    check_eq("mid_busy_after", busy, 1'b0);
    cnt = 0;
    repeat (50) begin @(posedge clk); #1; if (out_valid) cnt++; end
    check_eq("mid_no_valid", cnt, 0);

    // Random traffic, model-checked every cycle
    for (int i = 0; i < 3000; i++) begin
      in_x  = 16'($urandom);
      in_y  = 16'($urandom);
      in_z  = 16'($urandom);
      SW    = 2'($urandom);
      trig  = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 499) != 0);
      @(posedge clk); #1;
    end
    trig = 1'b0; reset = 1'b1;
    repeat (60) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
